branch_resolve_unit: RTL
========================

// Module: branch_resolve_unit
// PURPOSE
//  Resolution side of the branch predictor interface. Queues each prediction the predictor issues at fetch.
//  Compares each prediction with the outcome ID resolves for the same branch.
//  Returns registered training info (id_branch_info0) and the mispredict flag (pred_flag) to the predictor.
//  Drives the pipeline redirect/flush and holds a fixed recovery window after each mispredict.
// PARAMETERS
//  DEPTH        4   prediction queue entries (power of 2)
//  RECOVER_CYC  2   cycles spent in RECOVER after a mispredict (>=1)
//  CNT_W        16  width of saturating mispredict counter
// PORTS
//  clk             in   1   clock
//  resetn          in   1   synchronous active-low reset
//  stall           in   1   1 = freeze all internal state; registered outputs hold
//  pred_valid      in   1   predictor issued a prediction (BTB hit) for pred_pc
//  pred_pc         in   32  fetch pc of predicted branch
//  pred_pta        in   33  {dir[32], target[31:0]}
//  res_valid       in   1   ID resolved a control instruction this cycle
//  res_pc          in   32  pc of resolved instruction
//  res_taken       in   1   actual direction
//  res_target      in   32  actual target
//  res_type        in   2   actual branch type (BTYPE_* encoding)
//  id_branch_info0 out  35  {dir[34], target[33:2], type[1:0]} training info
//  upd_valid       out  1   id_branch_info0 valid this cycle
//  pred_flag       out  1   0 = InvalidPrediction (mispredict), 1 = prediction correct/none
//  redirect_valid  out  1   one-cycle fetch redirect pulse
//  redirect_pc     out  32  redirect address
//  flush           out  1   high during every RECOVER cycle
//  q_count         out  3   entries currently queued (0..DEPTH)
//  q_full          out  1   q_count == DEPTH
//  mispred_cnt     out  CNT_W  saturating mispredict count
// BEHAVIOUR
//  Reset (resetn=0 at clk edge): q_count=0; head/tail ptr=0; state=NORMAL.
//   All outputs 0 except pred_flag=1. Reset overrides stall and RECOVER mid-window.
//  Queue: FIFO of {pc,dir,target}.
//   Enqueue when pred_valid & state==NORMAL & (!q_full | dequeue same cycle).
//   Otherwise the prediction is dropped silently. Pointers wrap modulo DEPTH.
//  Resolve (res_valid, state==NORMAL):
//   Match: queue non-empty & head.pc==res_pc -> use head {dir,target}; dequeue head.
//   Head pc differs (stale entry): discard head; treat the branch as unpredicted (dir=0, target=0).
//   Queue empty: treat as unpredicted; no dequeue.
//   mispredict = (res_taken != dir) | (res_taken & res_target != target).
//  Outputs, registered; valid the cycle after res_valid (1-cycle latency):
//   upd_valid=1; id_branch_info0={res_taken,res_target,res_type}; pred_flag=~mispredict.
//   Without res_valid: upd_valid=0 and pred_flag=1; id_branch_info0 holds its value.
//  On mispredict (same output cycle):
//   redirect_valid=1 for exactly 1 cycle.
//   redirect_pc = res_taken ? res_target : res_pc+8 (skips delay slot; 32-bit wrap).
//   state->RECOVER; queue cleared (q_count=0, ptrs=0); mispred_cnt+1, saturating at all-ones.
//  FSM:
//   NORMAL -(res_valid & mispredict)-> RECOVER.
//   RECOVER: flush=1; pred_valid and res_valid ignored; internal counter runs RECOVER_CYC cycles,
//    then NORMAL. flush=1 for exactly RECOVER_CYC cycles.
//  Simultaneous enqueue+dequeue: allowed at full or empty-after-dequeue; q_count unchanged.
//   If the same cycle mispredicts, the clear wins and the enqueue is dropped.
//  stall=1: pointers, count, FSM, recovery counter and mispred_cnt frozen.
//   upd_valid and redirect_valid forced 0, so no event repeats; other outputs hold.
//   A res_valid seen under stall is ignored (ID re-presents it).
// TESTING
//  1. Reset: resetn=0 one cycle -> q_count=0, pred_flag=1, upd_valid=0, flush=0, mispred_cnt=0.
//  2. Correct prediction:
//     pred pc=0x100 pta={1,0x200}; res pc=0x100 taken=1 target=0x200
//     -> next cycle upd_valid=1, pred_flag=1, no redirect, q_count 1->0.
//  3. Direction mispredict:
//     pred {0,0x200} for pc 0x100; res taken=1 target=0x200
//     -> pred_flag=0, redirect_pc=0x200, flush high 2 cycles, q_count=0, mispred_cnt=1.
//  4. Not-taken miss:
//     pred {1,0x300} for pc 0x400; res taken=0 -> redirect_pc=0x408.
//     pred_valid pulsed during RECOVER is not enqueued.
//  5. Full/wrap:
//     enqueue 4 (q_full=1); 5th pred with no resolve dropped; resolve head + new pred same cycle
//     -> q_count stays 4; 6 further correct resolves wrap pointers with correct ordering.
//  6. Stall/stale/saturation:
//     stall with res_valid -> no upd_valid, state frozen.
//     head pc 0x100 vs res pc 0x180 -> head discarded, unpredicted compare.
//     preload mispred_cnt=0xFFFF, then mispredict -> stays 0xFFFF.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Resolution side of the branch predictor: queues fetch-time predictions, checks them against
// ID outcomes, returns registered training info and drives redirect/flush recovery.
module branch_resolve_unit #(
    parameter int DEPTH       = 4,
    parameter int RECOVER_CYC = 2,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    stall,
    input  logic                    pred_valid,
    input  logic [31:0]             pred_pc,
    input  logic [32:0]             pred_pta,
    input  logic                    res_valid,
    input  logic [31:0]             res_pc,
    input  logic                    res_taken,
    input  logic [31:0]             res_target,
    input  logic [1:0]              res_type,
    output logic [34:0]             id_branch_info0,
    output logic                    upd_valid,
    output logic                    pred_flag,
    output logic                    redirect_valid,
    output logic [31:0]             redirect_pc,
    output logic                    flush,
    output logic [$clog2(DEPTH):0]  q_count,
    output logic                    q_full,
    output logic [CNT_W-1:0]        mispred_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int RW = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

    typedef enum logic {NORMAL = 1'b0, RECOVER = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    rec_cnt_q, rec_cnt_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [PW:0]      count_q, count_d;
    logic [31:0]      ent_pc_q  [DEPTH];
    logic [31:0]      ent_pc_d  [DEPTH];
    logic             ent_dir_q [DEPTH];
    logic             ent_dir_d [DEPTH];
    logic [31:0]      ent_tgt_q [DEPTH];
    logic [31:0]      ent_tgt_d [DEPTH];
    logic [34:0]      info_q, info_d;
    logic             upd_q, upd_d;
    logic             flag_q, flag_d;
    logic             rv_q, rv_d;
    logic [31:0]      rpc_q, rpc_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;

    logic        in_normal, q_empty, full, do_res, hit, pdir, mispredict, deq, clear, enq;
    logic [31:0] ptgt;

    // A stale head (pc mismatch) is still consumed; the branch is then judged as unpredicted.
    assign in_normal  = (state_q == NORMAL);
    assign q_empty    = (count_q == '0);
    assign full       = (count_q == (PW+1)'(DEPTH));
    assign do_res     = !stall && in_normal && res_valid;
    assign hit        = !q_empty && (ent_pc_q[head_q] == res_pc);
    assign pdir       = hit && ent_dir_q[head_q];
    assign ptgt       = hit ? ent_tgt_q[head_q] : 32'd0;
    assign mispredict = (res_taken != pdir) || (res_taken && (res_target != ptgt));
    assign deq        = do_res && !q_empty;
    assign clear      = do_res && mispredict;
    assign enq        = !stall && in_normal && pred_valid && (!full || deq) && !clear;

    always_comb begin
        state_d   = state_q;
        rec_cnt_d = rec_cnt_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        ent_pc_d  = ent_pc_q;
        ent_dir_d = ent_dir_q;
        ent_tgt_d = ent_tgt_q;
        mcnt_d    = mcnt_q;
        upd_d     = do_res;
        rv_d      = clear;
        flag_d    = stall ? flag_q : !clear;
        info_d    = do_res ? {res_taken, res_target, res_type} : info_q;
        rpc_d     = clear ? (res_taken ? res_target : res_pc + 32'd8) : rpc_q;

        if (enq) begin
            ent_pc_d[tail_q]  = pred_pc;
            ent_dir_d[tail_q] = pred_pta[32];
            ent_tgt_d[tail_q] = pred_pta[31:0];
            tail_d            = tail_q + PW'(1);
        end
        if (deq) begin
            head_d = head_q + PW'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase

        if (clear) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            state_d   = RECOVER;
            rec_cnt_d = '0;
            if (mcnt_q != '1) begin
                mcnt_d = mcnt_q + CNT_W'(1);
            end
        end

        if (!in_normal && !stall) begin
            if (rec_cnt_q == RW'(RECOVER_CYC - 1)) begin
                state_d = NORMAL;
            end else begin
                rec_cnt_d = rec_cnt_q + RW'(1);
            end
        end

        flush_d = (state_d == RECOVER);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= NORMAL;
            rec_cnt_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            info_q    <= '0;
            upd_q     <= 1'b0;
            flag_q    <= 1'b1;
            rv_q      <= 1'b0;
            rpc_q     <= '0;
            flush_q   <= 1'b0;
            mcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            rec_cnt_q <= rec_cnt_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            info_q    <= info_d;
            upd_q     <= upd_d;
            flag_q    <= flag_d;
            rv_q      <= rv_d;
            rpc_q     <= rpc_d;
            flush_q   <= flush_d;
            mcnt_q    <= mcnt_d;
        end
    end

    // Entry storage needs no reset: only slots between head and tail are ever read.
    always_ff @(posedge clk) begin
        ent_pc_q  <= ent_pc_d;
        ent_dir_q <= ent_dir_d;
        ent_tgt_q <= ent_tgt_d;
    end

    assign id_branch_info0 = info_q;
    assign upd_valid       = upd_q;
    assign pred_flag       = flag_q;
    assign redirect_valid  = rv_q;
    assign redirect_pc     = rpc_q;
    assign flush           = flush_q;
    assign q_count         = count_q;
    assign q_full          = (count_q == (PW+1)'(DEPTH));
    assign mispred_cnt     = mcnt_q;

endmodule
